// File: rtl/key_ctl_multi_if.sv
// Keypad controller bus: raw active-low buttons and the dec level in, strobes and
// the packed digit vector out.
interface key_ctl_multi_if #(
  parameter int KEY_NUM = 4,
  parameter int DIGIT_W = 2
);
  logic [KEY_NUM-1:0]         key;
  logic                       enter;
  logic                       init;
  logic                       dec;
  logic                       enter_trig;
  logic                       init_trig;
  logic [KEY_NUM-1:0]         key_evt;
  logic [KEY_NUM*DIGIT_W-1:0] ctrl;

  modport master (
    output key, enter, init, dec,
    input  enter_trig, init_trig, key_evt, ctrl
  );

  modport slave (
    input  key, enter, init, dec,
    output enter_trig, init_trig, key_evt, ctrl
  );
endinterface

// File: rtl/key_ctl_multi.sv
// Debounced keypad controller: one wrap-around digit per key with up/down stepping,
// long-press auto-repeat and one-cycle enter/init strobes.
module key_ctl_multi #(
  parameter int KEY_NUM       = 4,
  parameter int DIGIT_W       = 2,
  parameter int DIGIT_MAX     = 3,
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_EN     = 1,
  parameter int LONG_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  key_ctl_multi_if.slave    bus_if
);

  localparam int CH       = KEY_NUM + 2;
  localparam int ENTER_CH = KEY_NUM;
  localparam int INIT_CH  = KEY_NUM + 1;
  localparam int DEB_W    = $clog2(DEB_CYCLES);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [CH-1:0]              raw_w;
  logic [CH-1:0]              press_w;
  logic [KEY_NUM-1:0]         held_w;
  logic [KEY_NUM-1:0]         rep_w;
  logic [KEY_NUM-1:0]         evt_w;
  logic [KEY_NUM*DIGIT_W-1:0] ctrl_w;
  logic [KEY_NUM-1:0]         key_evt_q;
  logic                       enter_trig_q;
  logic                       init_trig_q;

  assign raw_w = {bus_if.init, bus_if.enter, bus_if.key};

  // Identical synchroniser + debouncer per button; a press is a registered 1->0 of the level.
  for (genvar c = 0; c < CH; c++) begin : g_chan
    logic             sync1_q, sync2_q;
    logic             lvl_q, lvl_d, lvl_prev_q;
    logic [DEB_W-1:0] deb_q, deb_d;

    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    always_comb begin
      deb_d = deb_q;
      lvl_d = lvl_q;
      if (sync2_q == lvl_q) begin
        deb_d = '0;
      end else if (deb_q == DEB_W'(DEB_CYCLES - 1)) begin
        lvl_d = sync2_q;
        deb_d = '0;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end

    // NOTE: non-blocking assignments keep the two synchroniser stages as two distinct flops.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q    <= 1'b1;
        sync2_q    <= 1'b1;
        lvl_q      <= 1'b1;
        lvl_prev_q <= 1'b1;
        deb_q      <= '0;
      end else begin
        sync1_q    <= raw_w[c];
        sync2_q    <= sync1_q;
        lvl_q      <= lvl_d;
        lvl_prev_q <= lvl_q;
        deb_q      <= deb_d;
      end
    end

    assign press_w[c] = lvl_prev_q & ~lvl_q;

    if (c < KEY_NUM) begin : g_held
      assign held_w[c] = ~lvl_q;
    end
  end

  for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
    logic [DIGIT_W-1:0] digit_q, digit_d;

    if (REPEAT_EN != 0) begin : g_rep
      logic [HOLD_W-1:0] hold_q, hold_d;
      logic              holding_q, holding_d;
      logic              first_q, first_d;
      logic              rep;

      // hold_q counts cycles since the last event; the first gap is LONG, later gaps REPEAT.
      always_comb begin
        hold_d    = hold_q;
        holding_d = holding_q;
        first_d   = first_q;
        rep       = 1'b0;
        if (!held_w[k]) begin
          holding_d = 1'b0;
          hold_d    = '0;
          first_d   = 1'b0;
        end else if (press_w[k]) begin
          holding_d = 1'b1;
          hold_d    = HOLD_W'(1);
          first_d   = 1'b1;
        end else if (holding_q) begin
          if (hold_q == (first_q ? HOLD_W'(LONG_CYCLES) : HOLD_W'(REPEAT_CYCLES))) begin
            rep     = 1'b1;
            hold_d  = HOLD_W'(1);
            first_d = 1'b0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold_q    <= '0;
          holding_q <= 1'b0;
          first_q   <= 1'b0;
        end else begin
          hold_q    <= hold_d;
          holding_q <= holding_d;
          first_q   <= first_d;
        end
      end

      assign rep_w[k] = rep;
    end else begin : g_norep
      assign rep_w[k] = 1'b0;
    end

    assign evt_w[k] = press_w[k] | rep_w[k];

    // A clear on the same cycle wins over any step of this digit.
    always_comb begin
      digit_d = digit_q;
      if (press_w[INIT_CH]) begin
        digit_d = '0;
      end else if (evt_w[k]) begin
        if (bus_if.dec) begin
          digit_d = (digit_q == '0) ? DIGIT_W'(DIGIT_MAX) : digit_q - 1'b1;
        end else begin
          digit_d = (digit_q == DIGIT_W'(DIGIT_MAX)) ? '0 : digit_q + 1'b1;
        end
      end
    end

    // NOTE: the digits are plain flops rather than a memory, so they take the reset like any state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) digit_q <= '0;
      else     digit_q <= digit_d;
    end

    assign ctrl_w[k*DIGIT_W +: DIGIT_W] = digit_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_evt_q    <= '0;
      enter_trig_q <= 1'b0;
      init_trig_q  <= 1'b0;
    end else begin
      key_evt_q    <= evt_w;
      enter_trig_q <= press_w[ENTER_CH];
      init_trig_q  <= press_w[INIT_CH];
    end
  end

  assign bus_if.key_evt    = key_evt_q;
  assign bus_if.enter_trig = enter_trig_q;
  assign bus_if.init_trig  = init_trig_q;
  assign bus_if.ctrl       = ctrl_w;

endmodule

// File: doc/key_ctl_multi.md
Name: key_ctl_multi

Overview:
- Parametrised successor keypad controller for the lock design.
- Debounces KEY_NUM digit buttons plus enter and init; all buttons are active-low.
- Keeps one wrap-around digit counter per key, with optional decrement mode and long-press auto-repeat.
- Emits one-cycle enter/init strobes and the packed digit vector consumed by the lock compare logic.

Parameters:
- KEY_NUM, 4, number of digit keys/counters (1..16).
- DIGIT_W, 2, width of each digit counter.
- DIGIT_MAX, 3, largest digit value (≤ 2^DIGIT_W-1); counters wrap DIGIT_MAX→0 up, 0→DIGIT_MAX down.
- DEB_CYCLES, 500000, consecutive stable cycles needed to accept a new button level (≥2).
- REPEAT_EN, 1, 1 = auto-repeat on held digit keys, 0 = one event per press.
- LONG_CYCLES, 25000000, hold time from accepted press to first repeat event.
- REPEAT_CYCLES, 5000000, interval between subsequent repeat events.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- key  in  KEY_NUM  raw digit buttons, active-low
- enter  in  1  raw enter button, active-low
- init  in  1  raw init/clear button, active-low
- dec  in  1  level: 1 = pressed digit decrements, 0 = increments
- enter_trig  out  1  one-cycle strobe on accepted enter press
- init_trig  out  1  one-cycle strobe on accepted init press
- key_evt  out  KEY_NUM  one-cycle per-key strobe for each counted step (press or repeat)
- ctrl  out  KEY_NUM*DIGIT_W  packed digits; key i occupies bits [i*DIGIT_W +: DIGIT_W]

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - Synchronisers and debounced levels = 1 (released).
  - Debounce, hold and repeat counters = 0.
- Per button (KEY_NUM+2 channels, identical logic):
  - Synchronisation: 2-flop synchroniser into clk.
  - Debounce counter: clears whenever the synchronised sample equals the debounced level; otherwise increments.
  - Acceptance: when the count reaches DEB_CYCLES-1 while the sample still differs, the debounced level takes the sample and the counter clears.
  - Glitches shorter than DEB_CYCLES cycles never change the debounced level.
- Press = debounced 1→0. Release events are ignored.
- Press latency: the registered strobe (key_evt / enter_trig / init_trig) asserts exactly DEB_CYCLES+3 clocks after the raw input settles low, and lasts exactly 1 cycle.
- Auto-repeat (digit keys only, REPEAT_EN=1):
  - A hold counter starts at the press.
  - key_evt pulses again after LONG_CYCLES held cycles, then every REPEAT_CYCLES cycles while the debounced level stays 0.
  - Release clears the hold state immediately.
  - REPEAT_EN=0 removes the hold counter; only presses produce events.
- Counter update (registered, same edge key_evt asserts, visible on ctrl the next cycle):
  - dec=0: d = (d==DIGIT_MAX) ? 0 : d+1.
  - dec=1: d = (d==0) ? DIGIT_MAX : d-1.
  - dec is sampled on the event cycle; it is not debounced.
- init_trig has priority: on its assert cycle all digits load 0 and any simultaneous key_evt increment is discarded. key_evt itself still pulses.
- Simultaneous events:
  - Several keys are independent; all update the same cycle.
  - enter and init may both strobe in one cycle.
  - enter does not modify digits.
- Holding init does not repeat; a new clear needs release plus press.
- Reset mid-hold or mid-debounce:
  - State returns to released.
  - A button still held low after reset is accepted as a fresh press after DEB_CYCLES+3 cycles.
- Counters never exceed DIGIT_MAX.

Test Plan (KEY_NUM=4, DIGIT_W=3, DIGIT_MAX=5, DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, REPEAT_EN=1 unless stated):
- Reset then idle 50 cycles -> ctrl=0, all strobes 0. Assert rst asynchronously mid-cycle -> outputs 0 before next edge.
- key[0] low for 3 cycles, then high (glitch) -> no key_evt, ctrl=0. key[0] held low -> key_evt[0] 1 cycle at 7 clocks after the fall, ctrl[2:0]=1.
- Six press/release cycles on key[1] with dec=0 -> ctrl[5:3] steps 1,2,3,4,5,0. dec=1 from 0 -> 5.
- Hold key[2] 50 cycles after acceptance -> key_evt[2] at press, +20, +28, +36, +44, giving ctrl[8:6]=5. Repeat with REPEAT_EN=0 -> single event, value 1.
- Same-cycle init press and key[3] press with ctrl[11:9]=2 -> init_trig=1, key_evt[3]=1, ctrl=0 next cycle.
- enter press -> enter_trig 1 cycle, ctrl unchanged; held 100 cycles -> no further enter_trig.
